// File: rtl/ram_mp_pkg.sv
// ram_mp_pkg: shared types and helpers for the multi-read-port RAM.
// Holds the clear-engine state enum and the byte-merge function that the
// write path and the write-to-read forwarding path both use, so the two
// can never disagree on how a partial write combines with old data.
package ram_mp_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } ram_mp_state_e;

    // One byte lane of a byte-enabled write: enabled lanes take the new data.
    function automatic logic [BYTE_W-1:0] ram_mp_merge(
        input logic [BYTE_W-1:0] old_byte,
        input logic [BYTE_W-1:0] new_byte,
        input logic              be
    );
        return be ? new_byte : old_byte;
    endfunction

endpackage

// File: rtl/ram_mp_if.sv
// ram_mp_if: bus bundle for ram_mp (clear request, write port, read ports).
// The master side drives requests and addresses; the slave side (the RAM)
// returns o_ready and the packed registered read data.
interface ram_mp_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 1024,
    parameter int NRD    = 2,
    parameter int ADDR_W = $clog2(DEPTH)
);
    logic                    i_clear;
    logic                    o_ready;
    logic                    i_we;
    logic [DATA_W/8-1:0]     i_wbe;
    logic [ADDR_W-1:0]       i_waddr;
    logic [DATA_W-1:0]       i_wdata;
    logic [NRD*ADDR_W-1:0]   i_raddr;
    logic [NRD*DATA_W-1:0]   o_rdata;

    modport master (
        output i_clear, i_we, i_wbe, i_waddr, i_wdata, i_raddr,
        input  o_ready, o_rdata
    );

    modport slave (
        input  i_clear, i_we, i_wbe, i_waddr, i_wdata, i_raddr,
        output o_ready, o_rdata
    );
endinterface

// File: rtl/ram_mp_clear_fsm.sv
// ram_mp_clear_fsm: zero-fill sequencer for ram_mp.
// Sweeps a pointer from 0 to DEPTH-1 after reset or an i_clear request,
// emitting one clear write per cycle. o_ready is high only in IDLE, so it
// rises on the same edge that writes the last word.
module ram_mp_clear_fsm
    import ram_mp_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    output logic              o_ready,
    output logic              o_clr_we,
    output logic [ADDR_W-1:0] o_clr_addr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    ram_mp_state_e     r_state;
    ram_mp_state_e     w_state_next;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_ptr_next;

    // State and pointer registers; reset always restarts the sweep at 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CLEAR;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
        end
    end

    // Next state: walk the pointer while clearing; a clear request in IDLE restarts.
    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        if (r_state == CLEAR) begin
            if (r_ptr == LAST_ADDR) begin
                w_state_next = IDLE;
                w_ptr_next   = '0;
            end else begin
                w_ptr_next   = r_ptr + ADDR_W'(1);
            end
        end else if (i_clear) begin
            w_state_next = CLEAR;
            w_ptr_next   = '0;
        end
    end

    // Outputs: clear strobe and address while sweeping, ready otherwise.
    always_comb begin
        o_ready    = (r_state == IDLE);
        o_clr_we   = (r_state == CLEAR);
        o_clr_addr = r_ptr;
    end

endmodule

// File: rtl/ram_mp.sv
// ram_mp: parametrised synchronous RAM with one byte-enabled write port,
// NRD registered read ports and a built-in zero-fill engine.
// Optional build macro RAM_MP_BYPASS_EN: when defined, a read port whose
// address matches an accepted write in the same cycle returns the merged
// word; when undefined, it returns the old word (read-before-write).
// Addresses >= DEPTH drop writes and read back as zero.
module ram_mp
    import ram_mp_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 1024,
    parameter int NRD    = 2,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic     clk,
    input  logic     rst,
    ram_mp_if.slave  io_bus
);

    localparam int                NBYTES  = DATA_W / BYTE_W;
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_ready;
    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;
    logic              w_wr_in_range;
    logic              w_user_we;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_old_word;
    logic [DATA_W-1:0] w_merged;
    logic [DATA_W-1:0] w_mem_wdata;

    ram_mp_clear_fsm #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_clear_fsm (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (io_bus.i_clear),
        .o_ready    (w_ready),
        .o_clr_we   (w_clr_we),
        .o_clr_addr (w_clr_addr)
    );

    assign io_bus.o_ready = w_ready;

    // A user write is accepted only in IDLE, in range, and not pre-empted by a clear.
    assign w_wr_in_range = ({1'b0, io_bus.i_waddr} < DEPTH_L);
    assign w_user_we     = w_ready && io_bus.i_we && !io_bus.i_clear && w_wr_in_range;
    assign w_old_word    = w_wr_in_range ? r_mem[io_bus.i_waddr] : '0;

    genvar gi;
    generate
        for (gi = 0; gi < NBYTES; gi++) begin : g_lane
            assign w_merged[gi*BYTE_W +: BYTE_W] = ram_mp_merge(
                w_old_word[gi*BYTE_W +: BYTE_W],
                io_bus.i_wdata[gi*BYTE_W +: BYTE_W],
                io_bus.i_wbe[gi]);
        end
    endgenerate

    // Clear writes and user writes are mutually exclusive (ready is low while clearing).
    assign w_mem_we    = !rst && (w_clr_we || w_user_we);
    assign w_mem_addr  = w_clr_we ? w_clr_addr : io_bus.i_waddr;
    assign w_mem_wdata = w_clr_we ? '0 : w_merged;

    // Single write port into the array; the array itself carries no reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_wdata;
        end
    end

    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rd
            logic [ADDR_W-1:0] w_raddr;
            logic              w_rd_in_range;
            logic              w_hit;
            logic [DATA_W-1:0] w_rd_word;
            logic [DATA_W-1:0] r_rdata;

            assign w_raddr       = io_bus.i_raddr[gi*ADDR_W +: ADDR_W];
            assign w_rd_in_range = ({1'b0, w_raddr} < DEPTH_L);
            assign w_rd_word     = w_rd_in_range ? r_mem[w_raddr] : '0;
`ifdef RAM_MP_BYPASS_EN
            assign w_hit = w_user_we && (w_raddr == io_bus.i_waddr);
`else
            assign w_hit = 1'b0;
`endif

            // Registered read port; forced to zero in reset and while sweeping.
            always_ff @(posedge clk) begin
                if (rst || !w_ready) begin
                    r_rdata <= '0;
                end else if (w_hit) begin
                    r_rdata <= w_merged;
                end else begin
                    r_rdata <= w_rd_word;
                end
            end

            assign io_bus.o_rdata[gi*DATA_W +: DATA_W] = r_rdata;
        end
    endgenerate

endmodule
